// File: rtl/seq_digit_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB first,
// with a valid/ready handshake on both operand and result sides.
module seq_digit_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    // state   | meaning
    // ST_IDLE | waiting for operands, last result held on s/cout/ovf
    // ST_RUN  | one digit added per cycle, STEPS cycles
    // ST_DONE | result valid, held until out_ready
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_sub;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT:0]   w_dsum;
    logic             w_cmsb;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    always_comb begin
        w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, r_carry};
        // carry into the digit's top bit; on the final step this is the carry into bit WIDTH-1
        w_cmsb = w_dsum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
        w_last = (r_cnt == CW'(STEPS - 1));
        w_res_next = r_res >> DIGIT;
        w_res_next[WIDTH-1 -: DIGIT] = w_dsum[DIGIT-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_sub     <= 1'b0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a       <= a;
                        r_b       <= b ^ {WIDTH{sub}};
                        r_sub     <= sub;
                        r_carry   <= cin ^ sub;
                        r_cnt     <= '0;
                        r_state   <= ST_RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_res   <= w_res_next;
                    r_carry <= w_dsum[DIGIT];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        s         <= w_res_next;
                        cout      <= w_dsum[DIGIT] ^ r_sub;
                        ovf       <= w_cmsb ^ w_dsum[DIGIT];
                        r_state   <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state   <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_digit_adder.md
SEQ_DIGIT_ADDER -- requirements
Module: seq_digit_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 2, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, DIGIT >= 1; STEPS = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-010 SHALL have port sub  input  1  0 = A+B+cin, 1 = A-B-cin.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port s  output  WIDTH  sum/difference modulo 2^WIDTH.
REQ-014 SHALL have port cout  output  1  carry-out (add) / borrow-out (subtract).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-016 SHALL have port busy  output  1  high in RUN and DONE states.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 In IDLE, on in_valid=1 at a clock edge, SHALL capture a, b XOR {WIDTH{sub}}, sub, initial carry = cin XOR sub, clear step counter, go to RUN.
REQ-019 In RUN, each cycle SHALL add the DIGIT LSBs of the captured operands plus carry register, place DIGIT sum bits into the result register MSB end (shift right), update carry, increment step counter.
REQ-020 After the STEPS-th RUN cycle SHALL go to DONE; out_valid SHALL first be high exactly STEPS cycles after the accepting edge.
REQ-021 SHALL record carry into bit WIDTH-1 during the final step; ovf = that carry XOR final carry out of bit WIDTH-1.
REQ-022 cout SHALL equal final carry when sub=0 and its inverse (borrow) when sub=1.
REQ-023 s, cout, ovf SHALL hold stable throughout DONE regardless of out_ready duration.
REQ-024 In DONE, on out_ready=1 at an edge SHALL return to IDLE; no new operand accepted on that same edge (minimum issue interval STEPS+2 cycles).
REQ-025 in_valid while not in IDLE SHALL be ignored; a, b, cin, sub changes after acceptance SHALL not affect the result.
REQ-026 out_ready while not in DONE SHALL be ignored.
REQ-027 WIDTH=DIGIT SHALL give STEPS=1 and behave identically to a single-cycle adder registered once.
REQ-028 s, cout, ovf SHALL retain the last result in IDLE until the next result is produced.

Reset
REQ-029 rst_n=0 at an edge SHALL force IDLE, in_ready=1, out_valid=0, busy=0, s=0, cout=0, ovf=0, carry and counter 0, in any state including mid-RUN and DONE.
REQ-030 A transaction interrupted by reset SHALL be discarded; no out_valid SHALL follow it.
REQ-031 in_valid asserted during reset SHALL not be accepted.

Verification (WIDTH=8, DIGIT=2, STEPS=4 unless stated)
REQ-032 add a=0xFF, b=0x01, cin=0 -> out_valid 4 cycles after accept, s=0x00, cout=1, ovf=0.
REQ-033 add a=0x7F, b=0x01, cin=1 -> s=0x81, cout=0, ovf=1.
REQ-034 sub a=0x10, b=0x20, cin=0 -> s=0xF0, cout=1, ovf=0; sub a=0x80, b=0x01, cin=0 -> s=0x7F, cout=0, ovf=1.
REQ-035 out_ready held low 5 cycles in DONE, in_valid pulsed meanwhile -> s/cout/ovf stable, in_ready=0, pulsed operands not accepted.
REQ-036 rst_n low 1 cycle during step 2 of RUN -> next cycle IDLE, all outputs 0, no out_valid; subsequent a=0x03+b=0x05 -> s=0x08.
REQ-037 WIDTH=16, DIGIT=16: a=0xFFFF, b=0x0001 -> out_valid 1 cycle after accept, s=0x0000, cout=1; WIDTH=16, DIGIT=1: same operands, 16-cycle latency, same result.
